// File: rtl/fir_coef_bank_ctrl.sv
// fir_coef_bank_ctrl
//   Double-buffered FIR coefficient bank controller. A host streams N signed
//   coefficients (tap 0 first) into a shadow bank over a valid/ready
//   handshake. A load of the correct length waits in PEND until the next
//   sample_tick. On that tick the shadow bank is copied into the active bank,
//   so the filter never sees a partially written coefficient set. A load of
//   the wrong length produces a one-cycle err_len pulse. An abort discards the
//   load without touching the active bank.
//
// Parameters
//   N   number of taps (2..64)
//   CW  signed coefficient width
//
// Ports
//   clk          rising-edge clock
//   n_rst        asynchronous active-low reset
//   wr_valid     host beat valid
//   wr_ready     controller can accept a beat (IDLE/LOAD, out of reset)
//   wr_data      signed coefficient
//   wr_last      final beat of a load
//   abort        discard the load in progress or pending
//   sample_tick  filter sample-boundary strobe; the swap happens only here
//   coef_flat    active bank, tap k at [k*CW +: CW]
//   busy         high in LOAD or PEND
//   swap_done    one-cycle pulse, coincident with the coef_flat update
//   err_len      one-cycle pulse on a bad load length
//   cksum        signed sum of the committed set (CW+7 bits)
//
// Build option
//   FIR_COEF_CKSUM_EN  when defined, a running sum of the accepted beats is
//                      committed to cksum at the swap. When undefined, cksum
//                      is tied to zero.

module fir_coef_bank_ctrl #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic signed [CW-1:0] wr_data,
  input  logic                 wr_last,
  input  logic                 abort,
  input  logic                 sample_tick,
  output logic [N*CW-1:0]      coef_flat,
  output logic                 busy,
  output logic                 swap_done,
  output logic                 err_len,
  output logic signed [CW+6:0] cksum
);

  localparam int unsigned IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PEND, S_ERR} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 beat;
  logic                 wr_en;
  logic                 swap;
  logic signed [CW-1:0] shadow_q [N];
  logic [N*CW-1:0]      active_q;
  logic                 swap_done_q;

  // wr_ready is gated by n_rst so that it reads 0 while reset is held.
  assign wr_ready  = n_rst & ((state_q == S_IDLE) | (state_q == S_LOAD));
  assign beat      = wr_valid & wr_ready;
  assign busy      = (state_q == S_LOAD) | (state_q == S_PEND);
  assign err_len   = (state_q == S_ERR);
  assign swap_done = swap_done_q;
  assign coef_flat = active_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // idx_q is always 0 in IDLE, because every path back to IDLE clears it.
  // The first beat therefore lands in shadow[0] through the same write port.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    swap    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (beat && !abort) begin
          if (wr_last && (N > 1)) begin
            state_d = S_ERR;
          end else begin
            wr_en   = 1'b1;
            idx_d   = IW'(1);
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else if (beat) begin
          if (wr_last && (idx_q == LAST_IDX)) begin
            wr_en   = 1'b1;
            idx_d   = '0;
            state_d = S_PEND;
          end else if (wr_last || (idx_q == LAST_IDX)) begin
            idx_d   = '0;
            state_d = S_ERR;
          end else begin
            wr_en = 1'b1;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sample_tick) begin
          swap    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned k = 0; k < N; k++) shadow_q[k] <= '0;
      active_q    <= '0;
      swap_done_q <= 1'b0;
    end else begin
      if (wr_en) shadow_q[idx_q] <= wr_data;
      if (swap) begin
        for (int unsigned k = 0; k < N; k++) active_q[k*CW +: CW] <= shadow_q[k];
      end
      swap_done_q <= swap;
    end
  end

`ifdef FIR_COEF_CKSUM_EN
  logic signed [CW+6:0] acc_q;
  logic signed [CW+6:0] cksum_q;

  // The first beat of a load restarts the sum, which is the same as clearing
  // it on entry to LOAD.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q   <= '0;
      cksum_q <= '0;
    end else begin
      if (wr_en) acc_q <= ((state_q == S_IDLE) ? '0 : acc_q) + (CW+7)'(wr_data);
      if (swap)  cksum_q <= acc_q;
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule
